// File: rtl/winocnn_mem_pkg.sv
// Shared definitions for the Winograd CNN memory scan loader/unloader pair.
package winocnn_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } unload_state_t;

   localparam int unsigned MEM_WORD_WIDTH = 512;
   localparam int unsigned MEM_NUM_ROWS   = 128;
   localparam int unsigned MEM_DATA_WIDTH = 288;

   function automatic int unsigned row_idx_width(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/memory_unloader_if.sv
// Beat stream from the memory unloader: data, row tag and valid/ready handshake.
interface memory_unloader_if #(
   parameter int unsigned DATA_WIDTH = winocnn_mem_pkg::MEM_DATA_WIDTH,
   parameter int unsigned ROW_W      = winocnn_mem_pkg::row_idx_width(winocnn_mem_pkg::MEM_NUM_ROWS)
);

   logic [DATA_WIDTH-1:0] scan_out;
   logic                  scan_valid;
   logic                  scan_ready;
   logic [ROW_W-1:0]      row_index;

   modport master (
      output scan_out,
      output scan_valid,
      output row_index,
      input  scan_ready
   );

   modport slave (
      input  scan_out,
      input  scan_valid,
      input  row_index,
      output scan_ready
   );

endinterface

// File: rtl/memory_unloader.sv
// Streams a window of rows from a parallel word array, one registered beat per row,
// over a valid/ready interface with zero-bubble throughput.
module memory_unloader
   import winocnn_mem_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = MEM_WORD_WIDTH,
   parameter int unsigned NUM_ROWS   = MEM_NUM_ROWS,
   parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
   localparam int unsigned ROW_W     = row_idx_width(NUM_ROWS),
   localparam int unsigned CNT_W     = ROW_W + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] memory [NUM_ROWS],
   input  logic                  start,
   input  logic [ROW_W-1:0]      first_row,
   input  logic [CNT_W-1:0]      row_count,
   input  logic                  abort,
   memory_unloader_if.master     scan,
   output logic                  busy,
   output logic                  unload_done
);

   unload_state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] beat_q;
   logic                  valid_q;
   logic [ROW_W-1:0]      row_q;
   logic [CNT_W-1:0]      remaining_q;
   logic                  busy_q;
   logic                  done_q;

   logic [CNT_W-1:0]      count_sat;
   logic [ROW_W-1:0]      next_row;
   logic                  xfer;
   logic                  take_start;
   logic                  last_xfer;

   assign count_sat = (row_count > CNT_W'(NUM_ROWS)) ? CNT_W'(NUM_ROWS) : row_count;
   assign next_row  = (row_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
   assign xfer      = valid_q && scan.scan_ready;

   always_comb begin
      state_d    = state_q;
      take_start = 1'b0;
      last_xfer  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               take_start = 1'b1;
               state_d    = (count_sat == '0) ? DONE : STREAM;
            end
         end
         STREAM: begin
            // abort outranks completion, even when the final beat moves on this edge
            if (abort) begin
               state_d = IDLE;
            end else if (xfer && remaining_q == CNT_W'(1)) begin
               last_xfer = 1'b1;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beat_q      <= '0;
         valid_q     <= 1'b0;
         row_q       <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (take_start) begin
         remaining_q <= count_sat;
         done_q      <= (count_sat == '0);
         if (count_sat != '0) begin
            row_q   <= first_row;
            beat_q  <= memory[first_row][DATA_WIDTH-1:0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
         end
      end else if (state_q == STREAM) begin
         if (xfer) begin
            remaining_q <= remaining_q - CNT_W'(1);
         end
         if (abort || last_xfer) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else if (xfer) begin
            // next row is registered on the transfer edge so back-to-back beats need no bubble
            row_q  <= next_row;
            beat_q <= memory[next_row][DATA_WIDTH-1:0];
         end
         if (last_xfer) begin
            done_q <= 1'b1;
         end
      end
   end

   assign scan.scan_out   = beat_q;
   assign scan.scan_valid = valid_q;
   assign scan.row_index  = row_q;
   assign busy            = busy_q;
   assign unload_done     = done_q;

endmodule

// File: doc/memory_unloader.md
Name: memory_unloader

Overview:
- Read-side counterpart of the row-by-row memory scan loader.
- Walks a parallel word array (the loaded or result memory), one row per beat, over a window `first_row..first_row+row_count-1`.
- Each beat is streamed out as a `DATA_WIDTH` slice on a valid/ready interface.
- Used to dump result memories to the testbench or chip scan-out path after a Winograd CNN layer completes.

Parameters:
- `WORD_WIDTH`, 512, width of one memory row.
- `NUM_ROWS`, 128, number of rows in the array; must be ≥ 2.
- `DATA_WIDTH`, 288, width of a streamed beat; must be ≤ `WORD_WIDTH`.

Ports:
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `memory`  in  `WORD_WIDTH` × `NUM_ROWS`  unpacked source array; must be held stable while `busy`=1.
- `start`  in  1  one-cycle request to begin an unload; honoured only when not `busy`.
- `first_row`  in  `$clog2(NUM_ROWS)`  first row index; sampled on accepted `start`.
- `row_count`  in  `$clog2(NUM_ROWS)+1`  rows to send, 0..`NUM_ROWS`; sampled on accepted `start`.
- `abort`  in  1  synchronous cancel of an in-progress unload.
- `scan_out`  out  `DATA_WIDTH`  beat data = `memory[row][DATA_WIDTH-1:0]`.
- `scan_valid`  out  1  `scan_out` holds a valid beat.
- `scan_ready`  in  1  downstream accepts the beat this cycle.
- `row_index`  out  `$clog2(NUM_ROWS)`  row index of the beat on `scan_out`.
- `busy`  out  1  unload in progress.
- `unload_done`  out  1  sticky completion flag.

Behaviour:
- Reset values, asynchronous with `reset`=0: state IDLE; `scan_out`=0, `scan_valid`=0, `row_index`=0, `busy`=0, `unload_done`=0; internal counters 0.

States and transitions:
- IDLE to STREAM on `start`=1 with `row_count`≠0.
- IDLE to DONE on `start`=1 with `row_count`=0; `unload_done` rises the next cycle and no beat is sent.
- STREAM to DONE when the last beat is accepted.
- STREAM to IDLE on `abort`.
- DONE to STREAM or DONE on `start`, same rules as from IDLE; DONE otherwise holds.

Start and latency:
- On accepted `start` at edge t:
  - `first_row` and `row_count` are latched;
  - `unload_done` clears;
  - `busy`=1 from t+1;
  - at t+1 `scan_valid`=1, `scan_out`=`memory[first_row][DATA_WIDTH-1:0]`, `row_index`=`first_row`.
- `start` while `busy` is ignored.

Handshake:
- Beat transfers on an edge where `scan_valid`&&`scan_ready`.
- While `scan_valid`=1 and `scan_ready`=0, `scan_out` and `row_index` hold unchanged.
- Zero-bubble: the next row is registered on the same edge as the transfer, so full throughput is one row per cycle.
- `scan_valid` does not depend combinationally on `scan_ready`.

Addressing:
- Next row = `row_index`+1, wrapping from `NUM_ROWS`-1 to 0; `NUM_ROWS` need not be a power of two.
- A remaining-beats counter (width `$clog2(NUM_ROWS)+1`) loads `row_count` and decrements per transfer.
- `row_count`=`NUM_ROWS` sends every row exactly once.
- `row_count` > `NUM_ROWS` is saturated to `NUM_ROWS`.

Width:
- Only bits [`DATA_WIDTH`-1:0] of each row are sent; upper bits are ignored.

Completion:
- On the edge transferring the last beat: `scan_valid`→0, `busy`→0, `unload_done`→1.
- `unload_done` stays 1 until the next accepted `start` or reset.

Abort:
- `abort`=1 in STREAM: next edge goes to IDLE, `scan_valid`=0, `busy`=0, `unload_done` stays 0.
- A transfer on the same edge as `abort` still counts as delivered.
- `abort` has priority over completion.
- `abort` outside STREAM is ignored.
- Same-cycle `abort` and `start` in IDLE or DONE: `start` wins.

Reset mid-operation:
- Immediate return to reset values; no partial beat is presented after reset release.

Decomposition:
- Shared package `winocnn_mem_pkg` holds:
  - `unload_state_t` enum (IDLE, STREAM, DONE);
  - default constants `MEM_WORD_WIDTH`=512, `MEM_NUM_ROWS`=128, `MEM_DATA_WIDTH`=288;
  - row-index width helper.
- The package is shared with the loader.
- No sub-module: row-index and beat counters plus the output register are a single module.

Test Plan:
- Full dump: `memory[i]`={`WORD_WIDTH`{i-based pattern}}, `first_row`=0, `row_count`=128, `scan_ready`=1 → 128 consecutive beats from cycle t+1, `scan_out`=`memory[i][287:0]`, `row_index`=i; `unload_done`=1 after beat 127.
- Wrap: `first_row`=126, `row_count`=4 → `row_index` sequence 126, 127, 0, 1; then `busy`=0 and `unload_done`=1.
- Backpressure: `scan_ready` toggles 1,0,0,1,… with `row_count`=5 → each row delivered exactly once, `scan_out` stable during stalls, 5 transfers total.
- `row_count`=0 → no `scan_valid` pulse; `unload_done`=1 one cycle after `start`.
- Abort after 2 transfers of 10 → IDLE next cycle, `unload_done`=0; a following `start` (`first_row`=3, `row_count`=1) sends row 3 only.
- Asynchronous reset (0) asserted mid-stream between clock edges → outputs 0 immediately; `start` while `busy` ignored (no restart of `row_index`).
